// File: rtl/led_fade_pwm.sv
// Three-channel LED driver: shared PWM counter and step prescaler, with per-channel
// brightness that ramps linearly up while requested and back down once released.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 4096
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [2:0]              led_req,
  output logic [2:0]              led_out,
  output logic                    busy,
  output logic [3*PWM_BITS-1:0]   level
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] LVL_ZERO = '0;
  localparam logic [PWM_BITS-1:0] LVL_ONE  = PWM_BITS'(1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_ONE  = STEP_W'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  logic [2:0]          req_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;

  logic [PWM_BITS-1:0] lvl_q    [3];
  logic [PWM_BITS-1:0] lvl_next [3];
  state_t              state_q    [3];
  state_t              state_next [3];
  logic [2:0]          out_next;

  // With STEP_DIV=1 the counter is pinned at 0 and every cycle is a tick.
  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_q    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      req_q    <= led_req;
      pwm_cnt  <= pwm_cnt + LVL_ONE;
      step_cnt <= step_tick ? '0 : step_cnt + STEP_ONE;
    end
  end

  // Next level/state per channel; the tick direction always follows the current req_q.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < 3; i++) begin
      lvl_next[i] = lvl_q[i];
      if (step_tick) begin
        if (req_q[i] && (lvl_q[i] != LVL_MAX)) begin
          lvl_next[i] = lvl_q[i] + LVL_ONE;
        end else if (!req_q[i] && (lvl_q[i] != LVL_ZERO)) begin
          lvl_next[i] = lvl_q[i] - LVL_ONE;
        end
      end

      if (req_q[i]) begin
        state_next[i] = (lvl_next[i] == LVL_MAX) ? ST_ON : ST_RISE;
      end else begin
        state_next[i] = (lvl_next[i] == LVL_ZERO) ? ST_OFF : ST_FALL;
      end

      out_next[i] = (state_next[i] == ST_ON) || (pwm_cnt < lvl_next[i]);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        lvl_q[i]   <= '0;
        state_q[i] <= ST_OFF;
      end
      led_out <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        lvl_q[i]   <= lvl_next[i];
        state_q[i] <= state_next[i];
      end
      led_out <= out_next;
    end
  end

  // busy decodes straight from the state flops, so it is a registered view of state_next.
  always_comb begin
    busy  = 1'b0;
    level = '0;
    for (int i = 0; i < 3; i++) begin
      if ((state_q[i] == ST_RISE) || (state_q[i] == ST_FALL)) begin
        busy = 1'b1;
      end
      level[i*PWM_BITS +: PWM_BITS] = lvl_q[i];
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: three instances (STEP_DIV 2, 4096, 1) sharing one clock,
// exercised one after another with hand-computed expectations.
module tb_led_fade_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [2:0]  req_a, req_b, req_c;
  logic [2:0]  out_a, out_b, out_c;
  logic        busy_a, busy_b, busy_c;
  logic [11:0] lvl_a, lvl_b, lvl_c;

  led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(2)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_a), .led_req(req_a),
    .led_out(out_a), .busy(busy_a), .level(lvl_a)
  );

  led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(4096)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_b), .led_req(req_b),
    .led_out(out_b), .busy(busy_b), .level(lvl_b)
  );

  led_fade_pwm #(.PWM_BITS(4), .STEP_DIV(1)) dut_c (
    .sys_clk(clk), .sys_rst_n(rst_c), .led_req(req_c),
    .led_out(out_c), .busy(busy_c), .level(lvl_c)
  );

  typedef struct {
    logic [2:0]  req;
    int          cycles;
    logic [11:0] lvl;
    logic        busy;
    logic [2:0]  out;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    req_a = v.req;
    step(v.cycles);
    checkOutput($sformatf("vec%0d level", idx), {20'd0, lvl_a}, {20'd0, v.lvl});
    checkOutput($sformatf("vec%0d busy", idx), {31'd0, busy_a}, {31'd0, v.busy});
    checkOutput($sformatf("vec%0d led_out", idx), {29'd0, out_a}, {29'd0, v.out});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    int   highs;

    // Edge k after release: tick when k is even, pwm_cnt before the edge = (k-1) mod 16.
    vecs[0] = '{3'b001,  1, 12'h000, 1'b0, 3'b000};
    vecs[1] = '{3'b001,  1, 12'h001, 1'b1, 3'b000};
    vecs[2] = '{3'b001,  2, 12'h002, 1'b1, 3'b000};
    vecs[3] = '{3'b001, 10, 12'h007, 1'b1, 3'b000};
    vecs[4] = '{3'b000,  1, 12'h007, 1'b1, 3'b000};
    vecs[5] = '{3'b000,  1, 12'h006, 1'b1, 3'b000};
    vecs[6] = '{3'b000,  2, 12'h005, 1'b1, 3'b001};
    vecs[7] = '{3'b000, 10, 12'h000, 1'b0, 3'b000};
    vecs[8] = '{3'b000,  4, 12'h000, 1'b0, 3'b000};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_a = 3'b111; req_b = 3'b001; req_c = 3'b101;

    for (int i = 0; i < 10; i++) begin
      step(1);
      checkOutput("reset led_out", {29'd0, out_a}, 32'd0);
      checkOutput("reset busy", {31'd0, busy_a}, 32'd0);
      checkOutput("reset level", {20'd0, lvl_a}, 32'd0);
    end

    rst_a = 1'b1;
    step(1);
    checkOutput("release edge1 busy", {31'd0, busy_a}, 32'd0);
    checkOutput("release edge1 level", {20'd0, lvl_a}, 32'd0);
    step(1);
    checkOutput("release edge2 busy", {31'd0, busy_a}, 32'd1);
    checkOutput("release edge2 level", {20'd0, lvl_a}, 32'h111);
    checkOutput("release edge2 led_out", {29'd0, out_a}, 32'd0);

    rst_a = 1'b0;
    #1;
    checkOutput("async clear level", {20'd0, lvl_a}, 32'd0);
    checkOutput("async clear busy", {31'd0, busy_a}, 32'd0);
    req_a = 3'b001;
    step(1);
    rst_a = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Full ramp of channel 0 from OFF.
    req_a = 3'b001;
    step(1);
    checkOutput("ramp start busy", {31'd0, busy_a}, 32'd0);
    checkOutput("ramp start level", {20'd0, lvl_a}, 32'd0);
    step(1);
    for (int k = 1; k <= 15; k++) begin
      checkOutput($sformatf("ramp level %0d", k), {20'd0, lvl_a}, k);
      checkOutput($sformatf("ramp idle ch1-2 %0d", k), {30'd0, out_a[2:1]}, 32'd0);
      if (k < 15) begin
        checkOutput($sformatf("ramp busy %0d", k), {31'd0, busy_a}, 32'd1);
        step(2);
      end
    end
    checkOutput("ramp top busy", {31'd0, busy_a}, 32'd0);
    checkOutput("ramp top led_out", {29'd0, out_a}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1);
      checkOutput($sformatf("on steady led_out %0d", i), {29'd0, out_a}, 32'd1);
      checkOutput($sformatf("on steady level %0d", i), {20'd0, lvl_a}, 32'h00f);
    end

    // Asynchronous reset in the middle of a ramp.
    rst_a = 1'b0;
    #1;
    step(1);
    rst_a = 1'b1;
    step(18);
    checkOutput("pre-reset level", {20'd0, lvl_a}, 32'd9);
    #2;
    rst_a = 1'b0;
    #1;
    checkOutput("mid-ramp reset level", {20'd0, lvl_a}, 32'd0);
    checkOutput("mid-ramp reset led_out", {29'd0, out_a}, 32'd0);
    checkOutput("mid-ramp reset busy", {31'd0, busy_a}, 32'd0);
    step(1);
    rst_a = 1'b1;
    step(1);
    checkOutput("restart edge1 level", {20'd0, lvl_a}, 32'd0);
    step(1);
    checkOutput("restart edge2 level", {20'd0, lvl_a}, 32'd1);
    checkOutput("restart edge2 busy", {31'd0, busy_a}, 32'd1);

    // Duty at L=5 with the slow prescaler: ticks land on edges 4096*n.
    rst_b = 1'b1;
    step(20479);
    checkOutput("duty pre-tick level", {20'd0, lvl_b}, 32'd4);
    step(1);
    checkOutput("duty level", {20'd0, lvl_b}, 32'd5);
    highs = 0;
    for (int j = 0; j < 16; j++) begin
      step(1);
      checkOutput($sformatf("duty cycle %0d", j), {31'd0, out_b[0]}, (j < 5) ? 32'd1 : 32'd0);
      if (out_b[0] === 1'b1) highs++;
    end
    checkOutput("duty high count", highs, 32'd5);
    checkOutput("duty level hold", {20'd0, lvl_b}, 32'd5);

    // Independence and request change on a tick cycle (tick every cycle).
    rst_c = 1'b1;
    step(1);
    checkOutput("indep edge1 level", {20'd0, lvl_c}, 32'h000);
    step(15);
    checkOutput("indep edge16 level", {20'd0, lvl_c}, 32'hf0f);
    checkOutput("indep edge16 busy", {31'd0, busy_c}, 32'd0);
    checkOutput("indep edge16 led_out", {29'd0, out_c}, 32'b101);
    req_c = 3'b010;
    step(1);
    checkOutput("indep edge17 level", {20'd0, lvl_c}, 32'hf0f);
    checkOutput("indep edge17 busy", {31'd0, busy_c}, 32'd0);
    checkOutput("indep edge17 led_out", {29'd0, out_c}, 32'b101);
    step(1);
    checkOutput("indep edge18 level", {20'd0, lvl_c}, 32'he1e);
    checkOutput("indep edge18 busy", {31'd0, busy_c}, 32'd1);
    checkOutput("indep edge18 led_out", {29'd0, out_c}, 32'b101);
    step(7);
    checkOutput("indep edge25 level", {20'd0, lvl_c}, 32'h787);
    checkOutput("indep edge25 busy", {31'd0, busy_c}, 32'd1);
    checkOutput("indep edge25 led_out", {29'd0, out_c}, 32'b000);
    step(7);
    checkOutput("indep edge32 level", {20'd0, lvl_c}, 32'h0f0);
    checkOutput("indep edge32 busy", {31'd0, busy_c}, 32'd0);
    checkOutput("indep edge32 led_out", {29'd0, out_c}, 32'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
